// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer: main road rests on green, side road is served on a
// sensor level or a latched pedestrian request, with a 1 s time base derived from clk.
module traffic_intersection_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int T_MAIN_MIN = 5,
    parameter int T_SIDE_G   = 6,
    parameter int T_YEL      = 2,
    parameter int T_ALLRED   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] main_led,
    output logic [2:0] side_led,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] LED_RED = 3'b001;
    localparam logic [2:0] LED_GRN = 3'b010;
    localparam logic [2:0] LED_YEL = 3'b100;

    typedef enum logic [2:0] {
        AR_M   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        AR_S   = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  sec_cnt_q, sec_cnt_d;
    logic [7:0]  last_sec;
    logic        ped_pend_q, ped_pend_d;
    logic        walk_en_q, walk_en_d;
    logic        ped_ack_q, ped_ack_d;
    logic [2:0]  main_led_q, main_led_d;
    logic [2:0]  side_led_q, side_led_d;
    logic        ped_walk_q, ped_walk_d;
    logic [2:0]  state_o_q, state_o_d;
    logic        tick;
    logic        at_last;
    logic        enter_side;
    logic        leave_side;

    assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign at_last = (sec_cnt_q == last_sec);

    always_comb begin
        state_d  = state_q;
        last_sec = 8'd0;
        case (state_q)
            AR_M: begin
                last_sec = 8'(T_ALLRED - 1);
                if (tick && at_last) state_d = MAIN_G;
            end
            MAIN_G: begin
                // sec_cnt saturates here; the road only yields once the minimum green is met.
                last_sec = 8'(T_MAIN_MIN - 1);
                if (tick && at_last && (side_req || ped_pend_q)) state_d = MAIN_Y;
            end
            MAIN_Y: begin
                last_sec = 8'(T_YEL - 1);
                if (tick && at_last) state_d = AR_S;
            end
            AR_S: begin
                last_sec = 8'(T_ALLRED - 1);
                if (tick && at_last) state_d = SIDE_G;
            end
            SIDE_G: begin
                last_sec = 8'(T_SIDE_G - 1);
                if (tick && at_last) state_d = SIDE_Y;
            end
            SIDE_Y: begin
                last_sec = 8'(T_YEL - 1);
                if (tick && at_last) state_d = AR_M;
            end
            default: state_d = AR_M;
        endcase
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        sec_cnt_d = sec_cnt_q;
        if (state_d != state_q) begin
            sec_cnt_d = 8'd0;
        end else if (tick && !at_last) begin
            sec_cnt_d = sec_cnt_q + 8'd1;
        end

        enter_side = (state_d == SIDE_G) && (state_q != SIDE_G);
        leave_side = (state_q == SIDE_G) && (state_d != SIDE_G);

        // A press on the entry cycle itself stays pending for the next side cycle.
        ped_pend_d = ped_pend_q;
        if (enter_side) ped_pend_d = 1'b0;
        if (ped_req)    ped_pend_d = 1'b1;

        walk_en_d = walk_en_q;
        if (enter_side)      walk_en_d = ped_pend_q;
        else if (leave_side) walk_en_d = 1'b0;

        ped_ack_d = enter_side && ped_pend_q;

        main_led_d = LED_RED;
        side_led_d = LED_RED;
        ped_walk_d = 1'b0;
        case (state_q)
            MAIN_G: main_led_d = LED_GRN;
            MAIN_Y: main_led_d = LED_YEL;
            SIDE_G: begin
                side_led_d = LED_GRN;
                ped_walk_d = walk_en_q;
            end
            SIDE_Y: side_led_d = LED_YEL;
            default: ;
        endcase
        state_o_d = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= AR_M;
            tick_cnt_q <= '0;
            sec_cnt_q  <= 8'd0;
            ped_pend_q <= 1'b0;
            walk_en_q  <= 1'b0;
            ped_ack_q  <= 1'b0;
            main_led_q <= LED_RED;
            side_led_q <= LED_RED;
            ped_walk_q <= 1'b0;
            state_o_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sec_cnt_q  <= sec_cnt_d;
            ped_pend_q <= ped_pend_d;
            walk_en_q  <= walk_en_d;
            ped_ack_q  <= ped_ack_d;
            main_led_q <= main_led_d;
            side_led_q <= side_led_d;
            ped_walk_q <= ped_walk_d;
            state_o_q  <= state_o_d;
        end
    end

    assign ped_ack  = ped_ack_q;
    assign main_led = main_led_q;
    assign side_led = side_led_q;
    assign ped_walk = ped_walk_q;
    assign state_o  = state_o_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with TICK_DIV=4 (one second = 4 clks).
// Sample index k counts posedges after reset release; outputs are read on the following negedge.
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       side_req;
    logic       ped_req;
    logic       ped_ack;
    logic [2:0] main_led;
    logic [2:0] side_led;
    logic       ped_walk;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_intersection_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .side_req (side_req),
        .ped_req  (ped_req),
        .ped_ack  (ped_ack),
        .main_led (main_led),
        .side_led (side_led),
        .ped_walk (ped_walk),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Both roads must never show a non-red lamp together.
    always @(negedge clk) begin
        n_checks++;
        if (main_led != 3'b001 && side_led != 3'b001) begin
            n_fail++;
            $display("FAIL conflict t=%0t main=%b side=%b (one must be 001)", $time, main_led, side_led);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        side_req = 1'b0;
        ped_req  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 5;
        if (main_led !== 3'b001) begin n_fail++; $display("FAIL reset_main got=%b exp=001", main_led); end
        if (side_led !== 3'b001) begin n_fail++; $display("FAIL reset_side got=%b exp=001", side_led); end
        if (ped_walk !== 1'b0)   begin n_fail++; $display("FAIL reset_walk got=%b exp=0", ped_walk); end
        if (ped_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ped_ack); end
        if (state_o !== 3'd0)    begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    endtask

    task automatic test_main_rest();
        logic [2:0] exp_main;
        apply_reset();
        for (int k = 1; k <= 120; k++) begin
            step();
            exp_main = (k <= 4) ? 3'b001 : 3'b010;
            n_checks += 2;
            if (main_led !== exp_main) begin n_fail++; $display("FAIL rest_main k=%0d got=%b exp=%b", k, main_led, exp_main); end
            if (side_led !== 3'b001)   begin n_fail++; $display("FAIL rest_side k=%0d got=%b exp=001", k, side_led); end
        end
    endtask

    task automatic test_side_cycle();
        logic [2:0] exp_main, exp_side, exp_st;
        apply_reset();
        side_req = 1'b1;
        for (int k = 1; k <= 76; k++) begin
            step();
            exp_main = 3'b001; exp_side = 3'b001;
            if (k <= 4)       exp_st = 3'd0;
            else if (k <= 24) begin exp_st = 3'd1; exp_main = 3'b010; end
            else if (k <= 32) begin exp_st = 3'd2; exp_main = 3'b100; end
            else if (k <= 36) exp_st = 3'd3;
            else if (k <= 60) begin exp_st = 3'd4; exp_side = 3'b010; end
            else if (k <= 68) begin exp_st = 3'd5; exp_side = 3'b100; end
            else if (k <= 72) exp_st = 3'd0;
            else              begin exp_st = 3'd1; exp_main = 3'b010; end
            n_checks += 3;
            if (main_led !== exp_main) begin n_fail++; $display("FAIL side_cyc_main k=%0d got=%b exp=%b", k, main_led, exp_main); end
            if (side_led !== exp_side) begin n_fail++; $display("FAIL side_cyc_side k=%0d got=%b exp=%b", k, side_led, exp_side); end
            if (state_o !== exp_st)    begin n_fail++; $display("FAIL side_cyc_state k=%0d got=%0d exp=%0d", k, state_o, exp_st); end
        end
        side_req = 1'b0;
    endtask

    task automatic test_late_side();
        logic [2:0] exp_main;
        apply_reset();
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k <= 4)       exp_main = 3'b001;
            else if (k <= 40) exp_main = 3'b010;
            else              exp_main = 3'b100;
            n_checks++;
            if (main_led !== exp_main) begin n_fail++; $display("FAIL late_side_main k=%0d got=%b exp=%b", k, main_led, exp_main); end
            if (k == 37) side_req = 1'b1;
        end
        side_req = 1'b0;
    endtask

    task automatic test_ped_walk();
        logic exp_ack, exp_walk;
        apply_reset();
        for (int k = 1; k <= 140; k++) begin
            step();
            exp_ack  = (k == 36);
            exp_walk = (k >= 37 && k <= 60);
            n_checks += 2;
            if (ped_ack !== exp_ack)   begin n_fail++; $display("FAIL ped_ack k=%0d got=%b exp=%b", k, ped_ack, exp_ack); end
            if (ped_walk !== exp_walk) begin n_fail++; $display("FAIL ped_walk k=%0d got=%b exp=%b", k, ped_walk, exp_walk); end
            if (k == 110) begin
                n_checks++;
                if (side_led !== 3'b010) begin n_fail++; $display("FAIL ped_second_side k=%0d got=%b exp=010", k, side_led); end
            end
            if (k == 10) ped_req = 1'b1;
            if (k == 11) ped_req = 1'b0;
            if (k == 72) side_req = 1'b1;
        end
        side_req = 1'b0;
    endtask

    task automatic test_ped_during_side();
        logic exp_ack, exp_walk;
        apply_reset();
        side_req = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            step();
            exp_ack  = (k == 104) || (k == 172);
            exp_walk = (k >= 105 && k <= 128) || (k >= 173 && k <= 196);
            n_checks += 2;
            if (ped_ack !== exp_ack)   begin n_fail++; $display("FAIL late_ped_ack k=%0d got=%b exp=%b", k, ped_ack, exp_ack); end
            if (ped_walk !== exp_walk) begin n_fail++; $display("FAIL late_ped_walk k=%0d got=%b exp=%b", k, ped_walk, exp_walk); end
            if (k == 40)  begin ped_req = 1'b1; side_req = 1'b0; end
            if (k == 41)  ped_req = 1'b0;
            if (k == 103) ped_req = 1'b1;
            if (k == 104) ped_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp_main;
        apply_reset();
        side_req = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k == 10) ped_req = 1'b1;
            if (k == 11) ped_req = 1'b0;
            if (k == 43) ped_req = 1'b1;
            if (k == 44) ped_req = 1'b0;
        end
        n_checks += 2;
        if (side_led !== 3'b010) begin n_fail++; $display("FAIL mid_pre_side got=%b exp=010", side_led); end
        if (ped_walk !== 1'b1)   begin n_fail++; $display("FAIL mid_pre_walk got=%b exp=1", ped_walk); end
        side_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks += 5;
        if (main_led !== 3'b001) begin n_fail++; $display("FAIL mid_rst_main got=%b exp=001", main_led); end
        if (side_led !== 3'b001) begin n_fail++; $display("FAIL mid_rst_side got=%b exp=001", side_led); end
        if (ped_walk !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_walk got=%b exp=0", ped_walk); end
        if (ped_ack !== 1'b0)    begin n_fail++; $display("FAIL mid_rst_ack got=%b exp=0", ped_ack); end
        if (state_o !== 3'd0)    begin n_fail++; $display("FAIL mid_rst_state got=%0d exp=0", state_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            exp_main = (k <= 4) ? 3'b001 : 3'b010;
            n_checks += 2;
            if (main_led !== exp_main) begin n_fail++; $display("FAIL mid_restart_main k=%0d got=%b exp=%b", k, main_led, exp_main); end
            if (side_led !== 3'b001)   begin n_fail++; $display("FAIL mid_restart_side k=%0d got=%b exp=001", k, side_led); end
        end
    endtask

    initial begin
        test_reset();
        test_main_rest();
        test_side_cycle();
        test_late_side();
        test_ped_walk();
        test_ped_during_side();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
- Sequences a two-road intersection: a main road and a side road, each with a red/green/yellow lamp group, plus a pedestrian walk lamp on the side crossing.
- Generates its own 1 s time base from clk and runs phases timed in whole seconds.
- Main road rests on green. The side road is served only on a vehicle-sensor level or a latched pedestrian request, and a req/ack pulse handshake reports service to the pedestrian-button logic.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per 1 s tick; sims use 4.
- T_MAIN_MIN, 5, minimum main-green seconds before yielding.
- T_SIDE_G, 6, side-green seconds.
- T_YEL, 2, yellow seconds, both roads.
- T_ALLRED, 1, all-red clearance seconds.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- side_req  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, single-cycle pulse
- ped_ack  out  1  single-cycle pulse when the latched pedestrian request is served
- main_led  out  3  main lamps: 001 red, 010 green, 100 yellow
- side_led  out  3  side lamps, same encoding
- ped_walk  out  1  walk lamp
- state_o  out  3  current state code, for debug

Behaviour:
- Reset (asynchronous, rst=1): all registers clear.
  - tick_cnt=0, sec_cnt=0, ped_pend=0, state=AR_M (0).
  - main_led=001, side_led=001, ped_walk=0, ped_ack=0, state_o=0.
- Tick generation:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle strobe while tick_cnt==TICK_DIV-1.
- Phase timing:
  - sec_cnt clears on every state change.
  - On tick: if sec_cnt==T-1 (T is the phase duration), the state advances; otherwise sec_cnt increments.
  - A timed phase therefore lasts exactly T ticks.
- State codes and transitions:
  - 0 AR_M: all red, T_ALLRED, then MAIN_G.
  - 1 MAIN_G: main green.
    - sec_cnt saturates at T_MAIN_MIN-1.
    - Once saturated, a tick with (side_req | ped_pend) moves to MAIN_Y; otherwise the state holds indefinitely.
  - 2 MAIN_Y: T_YEL, then AR_S.
  - 3 AR_S: all red, T_ALLRED, then SIDE_G.
  - 4 SIDE_G: T_SIDE_G, then SIDE_Y.
  - 5 SIDE_Y: T_YEL, then AR_M.
  - 6, 7: illegal; go to AR_M on the next clk.
- Pedestrian handshake:
  - ped_req sets ped_pend.
  - On the clk where the state enters SIDE_G:
    - walk_en is set if ped_pend=1.
    - ped_pend clears.
    - ped_ack pulses for one cycle, only if ped_pend was 1.
  - ped_req on that same entry cycle: set wins, so ped_pend stays 1 for the next cycle.
  - ped_req during SIDE_G: latched and served on the next side cycle, with no ack now.
  - walk_en clears on leaving SIDE_G.
- Outputs:
  - main_led, side_led, ped_walk and state_o are registered, decoded from the current state, and lag the state register by one clk.
  - Main lamps: green in MAIN_G, yellow in MAIN_Y, red otherwise.
  - Side lamps: green in SIDE_G, yellow in SIDE_Y, red otherwise.
  - ped_walk = walk_en while in SIDE_G.
  - Never both roads non-red in the same cycle.
- Rules:
  - All arithmetic is unsigned; sec_cnt is 8 bit, so every T is ≤255.
  - Parameters must be ≥1; a zero parameter is illegal.
- rst mid-phase: immediate return to the reset values; any pending ped request is lost.

Test Plan:
- Reset with side_req=0, ped_req=0, TICK_DIV=4:
  - after rst falls, main_led=001 for 4 clks, then 010 and holding ≥100 clks;
  - side_led stays 001.
- side_req=1 held from reset: MAIN_G lasts 20 clks (5 ticks), then main_led=100 for 8 clks, then both 001 for 4 clks, then side_led=010 for 24 clks, then 100 for 8 clks, then AR_M.
- side_req=1 asserted at second 8 of MAIN_G: MAIN_Y starts at the next tick (≤4 clks later).
- ped_req pulse during MAIN_G, side_req=0:
  - side cycle runs, with ped_walk=1 for all 24 SIDE_G clks;
  - exactly one ped_ack pulse, at SIDE_G entry;
  - ped_walk=0 on the following side cycle if no new press.
- ped_req pulse during SIDE_G: no ack in that cycle; with side_req=0 the next side cycle still occurs, acks, and walks.
- rst pulsed mid SIDE_G: outputs go to 001/001, walk=0 and ack=0 asynchronously, and the sequence restarts at AR_M.
- Assertion over all tests: never (main_led!=001 && side_led!=001).
